// File: rtl/mips_io_monitor_if.sv
// Bus bundle for the MIPS I/O monitor: processor store port, FIFO
// consumer port and verdict flags.
interface mips_io_monitor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic             rd_en;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             fifo_full;
    logic             overflow;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic             done;

    modport master (
        output start, memwrite, adr, writedata, rd_en,
        input  out_valid, out_data, fifo_full, overflow, pass, fail, timeout, done
    );

    modport slave (
        input  start, memwrite, adr, writedata, rd_en,
        output out_valid, out_data, fifo_full, overflow, pass, fail, timeout, done
    );
endinterface

// File: rtl/mips_io_monitor.sv
// Watches processor stores to a memory-mapped output port, judges the first
// value against EXPECT, and queues every observed port value in a small FIFO.
module mips_io_monitor #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] IOADR   = 8'hFF,
    parameter logic [WIDTH-1:0] EXPECT  = 8'h0D,
    parameter int               DEPTH   = 4,
    parameter int               TIMEOUT = 1000
) (
    input logic              clk_i,
    input logic              rst_ni,
    mips_io_monitor_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST   = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULLCNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TMO
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic ioWrite;
    logic pushReq;
    logic pushEn;
    logic popEn;
    logic fifoFull;

    assign ioWrite  = bus.memwrite && (bus.adr == IOADR);
    assign fifoFull = (count_q == FULLCNT);
    assign pushReq  = ioWrite && ((state_q == RUN) || (state_q == PASS) || (state_q == FAIL));
    assign popEn    = bus.rd_en && (count_q != '0);
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign pushEn   = pushReq && (!fifoFull || popEn);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (ioWrite) begin
                    state_d = (bus.writedata == EXPECT) ? PASS : FAIL;
                end else if (cnt_q == TLAST) begin
                    state_d = TMO;
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        wptr_d     = pushEn ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = popEn ? rptr_q + 1'b1 : rptr_q;
        overflow_d = overflow_q || (pushReq && fifoFull && !popEn);
        count_d    = count_q;
        if (pushEn && !popEn) begin
            count_d = count_q + 1'b1;
        end else if (popEn && !pushEn) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: contents are only visible while count_q is non-zero.
    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            mem[wptr_q] <= bus.writedata;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem[rptr_q];
    assign bus.fifo_full = fifoFull;
    assign bus.overflow  = overflow_q;
    assign bus.pass      = (state_q == PASS);
    assign bus.fail      = (state_q == FAIL);
    assign bus.timeout   = (state_q == TMO);
    assign bus.done      = (state_q == PASS) || (state_q == FAIL) || (state_q == TMO);
endmodule

// File: tb/tb_mips_io_monitor.sv
// Directed bench for mips_io_monitor: verdict checks inline, FIFO data checked
// by a scoreboard queue drained by an independent monitor process.
module tb_mips_io_monitor;
    logic clk;
    logic rstN;
    int   assertCount = 0;
    int   failCount   = 0;
    logic [7:0] sbQueue[$];

    mips_io_monitor_if #(.WIDTH(8)) bus ();
    mips_io_monitor_if #(.WIDTH(8)) busT ();

    mips_io_monitor dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus)
    );

    mips_io_monitor #(.TIMEOUT(16)) dutT (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (busT)
    );

    assign busT.start     = bus.start;
    assign busT.memwrite  = bus.memwrite;
    assign busT.adr       = bus.adr;
    assign busT.writedata = bus.writedata;
    assign busT.rd_en     = bus.rd_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: each accepted pop is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (rstN && bus.out_valid && bus.rd_en) begin
            if (sbQueue.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpectedPop: got %0h expected no data at %0t", bus.out_data, $time);
            end else begin
                checkOutput("fifoPopData", {24'd0, bus.out_data}, {24'd0, sbQueue.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic mw, input logic [7:0] a,
                                 input logic [7:0] wd, input logic rd);
        bus.start     = st;
        bus.memwrite  = mw;
        bus.adr       = a;
        bus.writedata = wd;
        bus.rd_en     = rd;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.memwrite  = 1'b0;
        bus.adr       = 8'h00;
        bus.writedata = 8'h00;
        bus.rd_en     = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic ioWrite(input logic [7:0] wd, input logic rd, input logic expectPush);
        if (expectPush) sbQueue.push_back(wd);
        applyStimulus(1'b0, 1'b1, 8'hFF, wd, rd);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_outValid"}, {31'd0, bus.out_valid}, 0);
        checkOutput({tag, "_fifoFull"}, {31'd0, bus.fifo_full}, 0);
        checkOutput({tag, "_overflow"}, {31'd0, bus.overflow}, 0);
        checkOutput({tag, "_pass"},     {31'd0, bus.pass}, 0);
        checkOutput({tag, "_fail"},     {31'd0, bus.fail}, 0);
        checkOutput({tag, "_timeout"},  {31'd0, bus.timeout}, 0);
        checkOutput({tag, "_done"},     {31'd0, bus.done}, 0);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        sbQueue.delete();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0; bus.memwrite = 1'b0; bus.adr = 8'h00;
        bus.writedata = 8'h00; bus.rd_en = 1'b0;
        rstN = 1'b1;
        #2 rstN = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        // Writes before start and to a neighbouring address are ignored.
        applyStimulus(1'b0, 1'b1, 8'hFE, 8'h0D, 1'b0);
        ioWrite(8'h0D, 1'b0, 1'b0);
        checkOutput("idleNoPush", {31'd0, bus.out_valid}, 0);
        checkOutput("idleNoVerdict", {31'd0, bus.done}, 0);

        // First port write matches after 50 cycles.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        idleCycles(50);
        applyStimulus(1'b0, 1'b1, 8'hFE, 8'h08, 1'b0);
        checkOutput("wrongAdrNoPush", {31'd0, bus.out_valid}, 0);
        ioWrite(8'h0D, 1'b0, 1'b1);
        checkOutput("passFlag", {31'd0, bus.pass}, 1);
        checkOutput("passDone", {31'd0, bus.done}, 1);
        checkOutput("passNotFail", {31'd0, bus.fail}, 0);
        checkOutput("passValid", {31'd0, bus.out_valid}, 1);
        checkOutput("passData", {24'd0, bus.out_data}, 32'h0D);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        checkOutput("passDrained", {31'd0, bus.out_valid}, 0);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("startIgnored", {31'd0, bus.pass}, 1);
        doReset();

        // Mismatch first, verdict then frozen; both values queued in order.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        ioWrite(8'h08, 1'b0, 1'b1);
        checkOutput("failFlag", {31'd0, bus.fail}, 1);
        checkOutput("failDone", {31'd0, bus.done}, 1);
        checkOutput("failNotPass", {31'd0, bus.pass}, 0);
        ioWrite(8'h0D, 1'b0, 1'b1);
        checkOutput("failSticky", {31'd0, bus.fail}, 1);
        checkOutput("failStillNoPass", {31'd0, bus.pass}, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        checkOutput("failDrained", {31'd0, bus.out_valid}, 0);
        doReset();

        // Fill, push+pop on full, then overflow.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) ioWrite(8'(i), 1'b0, 1'b1);
        checkOutput("fullAfter4", {31'd0, bus.fifo_full}, 1);
        checkOutput("noOverflowAt4", {31'd0, bus.overflow}, 0);
        ioWrite(8'h09, 1'b1, 1'b1);
        checkOutput("fullAfterPushPop", {31'd0, bus.fifo_full}, 1);
        checkOutput("noOverflowPushPop", {31'd0, bus.overflow}, 0);
        ioWrite(8'h05, 1'b0, 1'b0);
        checkOutput("overflowSet", {31'd0, bus.overflow}, 1);
        checkOutput("fullAfterDrop", {31'd0, bus.fifo_full}, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        checkOutput("emptyAfterPops", {31'd0, bus.out_valid}, 0);
        checkOutput("notFullAfterPops", {31'd0, bus.fifo_full}, 0);
        checkOutput("overflowHeld", {31'd0, bus.overflow}, 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        checkOutput("popEmptyIgnored", {31'd0, bus.out_valid}, 0);
        checkOutput("scoreboardDrained", sbQueue.size(), 0);
        doReset();

        // Asynchronous reset with two entries held, in the middle of a cycle.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        ioWrite(8'h0D, 1'b0, 1'b1);
        ioWrite(8'h0D, 1'b0, 1'b1);
        checkOutput("twoEntriesValid", {31'd0, bus.out_valid}, 1);
        #2 rstN = 1'b0;
        sbQueue.delete();
        #1 checkAllZero("asyncReset");
        @(posedge clk);
        #1 rstN = 1'b1;
        ioWrite(8'h0D, 1'b0, 1'b0);
        checkOutput("needsNewStart", {31'd0, bus.done}, 0);
        checkOutput("needsNewStartFifo", {31'd0, bus.out_valid}, 0);

        // Reset mid-RUN discards the run.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        idleCycles(3);
        doReset();
        ioWrite(8'h0D, 1'b0, 1'b0);
        checkOutput("midRunResetNoVerdict", {31'd0, bus.pass}, 0);
        doReset();

        // Timeout 16 cycles after the start edge on the short-timeout instance.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        idleCycles(15);
        checkOutput("tmoNotYet", {31'd0, busT.timeout}, 0);
        idleCycles(1);
        checkOutput("tmoFlag", {31'd0, busT.timeout}, 1);
        checkOutput("tmoDone", {31'd0, busT.done}, 1);
        checkOutput("tmoNotPass", {31'd0, busT.pass}, 0);
        ioWrite(8'h0D, 1'b0, 1'b1);
        checkOutput("tmoNoPush", {31'd0, busT.out_valid}, 0);
        checkOutput("tmoSticky", {31'd0, busT.timeout}, 1);
        checkOutput("tmoLateNoPass", {31'd0, busT.pass}, 0);
        doReset();

        // A port write on the deciding edge beats the timeout.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        idleCycles(15);
        ioWrite(8'h0D, 1'b0, 1'b1);
        checkOutput("lastCyclePass", {31'd0, busT.pass}, 1);
        checkOutput("lastCycleNoTmo", {31'd0, busT.timeout}, 0);
        checkOutput("lastCyclePushed", {31'd0, busT.out_valid}, 1);
        doReset();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
